sram_multiport_ctrl: RTL

Parametrised asynchronous-SRAM controller serving NUM_CH independent requesters (e.g. CPU PRG fetch, PPU CHR fetch, loader/DMA) through one external byte-wide SRAM. Arbitrates by round-robin or fixed priority and runs a configurable-length SETUP/ACCESS/DONE cycle. Returns per-channel read data with a one-cycle ack. Sits between the mapper/bus logic and the board SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 27 ++
 rtl/sram_multiport_ctrl_rr_arbiter.sv | 49 ++++
 rtl/sram_multiport_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// sram_ctrl_pkg : shared state encoding and sizing helper for the SRAM
//                 multiport controller.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Never returns 0, so a single-channel or single-wait build still gets a 1-bit index/counter.
    function automatic int clog2(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_multiport_ctrl_rr_arbiter.sv
// ============================================================================
// rr_arbiter : one-hot grant from a request vector, round-robin after
//              last_grant or fixed lowest-index priority.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int FIXED_PRIO = 0
) (
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        mask,
    input  logic [clog2(NUM_CH)-1:0] last_grant,
    input  logic                     enable,
    output logic [NUM_CH-1:0]        grant,
    output logic [clog2(NUM_CH)-1:0] idx
);

    localparam int IDX_W = clog2(NUM_CH);

    logic [NUM_CH-1:0] w_elig;

    assign w_elig = enable ? (req & ~mask) : '0;

    // Visit candidates in search order; the first eligible one wins.
    always_comb begin : p_search
        int pos;
        grant = '0;
        idx   = '0;
        pos   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (FIXED_PRIO != 0) begin
                pos = k - 1;
            end else begin
                pos = (int'(last_grant) + k) % NUM_CH;
            end
            if ((grant == '0) && w_elig[pos]) begin
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_multiport_ctrl.sv
// ============================================================================
// sram_multiport_ctrl : arbitrates NUM_CH requesters onto one asynchronous
//                       byte-wide SRAM with a SETUP/ACCESS/DONE cycle.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module sram_multiport_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 22,
    parameter int SRAM_ADDR_W = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 3,
    parameter int FIXED_PRIO  = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          we,
    input  logic [NUM_CH*ADDR_W-1:0]   addr,
    input  logic [NUM_CH*DATA_W-1:0]   wdata,
    output logic [NUM_CH-1:0]          ack,
    output logic [NUM_CH*DATA_W-1:0]   rdata,
    output logic                       busy,
    output logic [SRAM_ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]          sram_dq_o,
    output logic                       sram_dq_oe,
    input  logic [DATA_W-1:0]          sram_dq_i,
    output logic                       sram_cs_n,
    output logic                       sram_we_n
);

    localparam int IDX_W = clog2(NUM_CH);
    localparam int CNT_W = clog2(WAIT_CYCLES + 1);

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                sel_q, sel_d;
    logic [IDX_W-1:0]                last_q, last_d;
    logic                            we_q, we_d;
    logic [SRAM_ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]               wdata_q, wdata_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_CH-1:0]               w_grant;
    logic [IDX_W-1:0]                w_gnt_idx;
    logic [NUM_CH-1:0]               w_sel_onehot;
    logic [NUM_CH-1:0]               w_mask;
    logic                            w_arb_en;
    logic                            w_unused_addr;

    // Upper requester address bits are deliberately dropped; external decode owns them.
    assign w_unused_addr = ^addr;

    assign w_sel_onehot = NUM_CH'(1) << sel_q;
    assign w_arb_en     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    // The channel finishing in DONE still holds req; masking it avoids a second grant.
    assign w_mask       = (state_q == ST_DONE) ? w_sel_onehot : '0;

    rr_arbiter #(
        .NUM_CH     (NUM_CH),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req        (req),
        .mask       (w_mask),
        .last_grant (last_q),
        .enable     (w_arb_en),
        .grant      (w_grant),
        .idx        (w_gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (|w_grant) begin
                    state_d = ST_SETUP;
                    sel_d   = w_gnt_idx;
                    last_d  = w_gnt_idx;
                    we_d    = we[w_gnt_idx];
                    addr_d  = addr[int'(w_gnt_idx)*ADDR_W +: SRAM_ADDR_W];
                    wdata_d = wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d[sel_q] = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Pin controls decode straight from state so an async reset clears them at once.
    assign ack        = (state_q == ST_DONE) ? w_sel_onehot : '0;
    assign busy       = (state_q != ST_IDLE);
    assign rdata      = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = wdata_q;
    assign sram_dq_oe = we_q && (state_q != ST_IDLE);
    assign sram_cs_n  = (state_q == ST_IDLE);
    assign sram_we_n  = !((state_q == ST_ACCESS) && we_q);

endmodule

`default_nettype wire
